// File: rtl/sync_filter_multi.sv
// Multi-channel synchroniser: per-channel metastability chain, programmable
// stability filter on the synchronised level, and registered rise/fall pulses.
module sync_filter_multi #(
  parameter int   CHANNELS    = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 4,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] din,
  input  logic [CNT_W-1:0]    filt_len,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   dout_q;
    logic                   dout_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   sync_bit;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= {SYNC_STAGES{RST_VAL}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], din[i]};
      end
    end

    // A change is accepted once sync has differed from dout for filt_len+1
    // consecutive cycles; any matching cycle restarts the count.
    always_comb begin
      dout_d = dout_q;
      cnt_d  = cnt_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (sync_bit == dout_q) begin
        cnt_d = '0;
      end else if (cnt_q >= filt_len) begin
        dout_d = sync_bit;
        cnt_d  = '0;
        rise_d = sync_bit;
        fall_d = ~sync_bit;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= RST_VAL;
        cnt_q  <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        dout_q <= dout_d;
        cnt_q  <= cnt_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign dout[i] = dout_q;
    assign rise[i] = rise_q;
    assign fall[i] = fall_q;
  end

  assign changed = |(rise | fall);

endmodule

// File: tb/tb_sync_filter_multi.sv
// Bench for sync_filter_multi: expected pulse events are queued with their due
// cycle when din changes, and a negedge monitor pops and compares them.
module tb_sync_filter_multi;
  localparam int CH  = 4;
  localparam int CW  = 4;
  localparam int SYN = 2;

  logic          clk;
  logic          rst;
  logic [CH-1:0] din;
  logic [CW-1:0] filt_len;
  logic [CH-1:0] dout;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic          changed;

  int unsigned n_total;
  int unsigned n_bad;
  logic [15:0] cyc;
  logic [CH-1:0] exp_dout;

  // entry = {due cycle[15:0], dout, rise, fall}
  logic [27:0] exp_q[$];

  sync_filter_multi #(
    .CHANNELS(CH), .SYNC_STAGES(SYN), .CNT_W(CW), .RST_VAL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .filt_len(filt_len),
    .dout(dout), .rise(rise), .fall(fall), .changed(changed)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 16'd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (cyc=%0d)", tag, got, exp, cyc);
    end
  endtask

  // Queue an event due 'dly' edges after the next (sampling) edge.
  task automatic expect_evt(input int dly, input logic [CH-1:0] r, input logic [CH-1:0] f);
    logic [15:0] due;
    due = cyc + 16'(1 + dly);
    exp_dout = (exp_dout | r) & ~f;
    exp_q.push_back({due, exp_dout, r, f});
  endtask

  // Drive din at a negedge; if the change will be accepted, queue its event.
  task automatic drive(input logic [CH-1:0] v, input bit accepted);
    logic [CH-1:0] r;
    logic [CH-1:0] f;
    r = v & ~din;
    f = ~v & din;
    din = v;
    if (accepted) expect_evt(SYN + int'(filt_len), r, f);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [27:0] e;
    if (n_total < 32'hFFFF_0000) begin
      if ((rise | fall) != '0) begin
        if (exp_q.size() == 0) begin
          chk("spurious_pulse", {24'd0, rise, fall}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("evt_cyc", {16'd0, cyc}, {16'd0, e[27:12]});
          chk("evt_dout", {28'd0, dout}, {28'd0, e[11:8]});
          chk("evt_rise", {28'd0, rise}, {28'd0, e[7:4]});
          chk("evt_fall", {28'd0, fall}, {28'd0, e[3:0]});
          chk("changed_hi", {31'd0, changed}, 32'd1);
        end
      end else begin
        chk("changed_lo", {31'd0, changed}, 32'd0);
      end
    end
  end

  initial begin
    n_total  = 0;
    n_bad    = 0;
    cyc      = 16'd0;
    exp_dout = '0;
    // T1 reset with all inputs high
    rst      = 1'b1;
    din      = 4'hF;
    filt_len = 4'd0;
    wait_cyc(3);
    chk("rst_dout", {28'd0, dout}, 32'd0);
    chk("rst_rise", {28'd0, rise}, 32'd0);
    chk("rst_fall", {28'd0, fall}, 32'd0);
    rst = 1'b0;
    expect_evt(SYN, 4'hF, 4'h0);
    wait_cyc(6);
    chk("t1_dout", {28'd0, dout}, 32'hF);

    // T2 filter latency and 3-cycle glitch on ch0
    drive(4'h0, 1'b1);
    wait_cyc(6);
    filt_len = 4'd3;
    wait_cyc(2);
    drive(4'h1, 1'b1);
    wait_cyc(10);
    drive(4'h0, 1'b1);
    wait_cyc(10);
    drive(4'h1, 1'b0);
    wait_cyc(3);
    drive(4'h0, 1'b0);
    wait_cyc(10);
    chk("t2_glitch_dout", {28'd0, dout}, 32'h0);

    // T3 boundary on ch1: 4 cycles accepted, 3 rejected
    drive(4'h2, 1'b1);
    wait_cyc(4);
    drive(4'h0, 1'b1);
    wait_cyc(12);
    drive(4'h2, 1'b0);
    wait_cyc(3);
    drive(4'h0, 1'b0);
    wait_cyc(10);
    chk("t3_dout", {28'd0, dout}, 32'h0);

    // T4 simultaneous rise and fall
    filt_len = 4'd2;
    wait_cyc(1);
    drive(4'b0101, 1'b1);
    wait_cyc(10);
    drive(4'b1010, 1'b1);
    wait_cyc(10);
    chk("t4_dout", {28'd0, dout}, 32'hA);

    // T5 filt_len decreased mid-count: accept on the next edge
    filt_len = 4'd15;
    wait_cyc(1);
    drive(4'b1110, 1'b0);
    wait_cyc(8);
    filt_len = 4'd4;
    expect_evt(0, 4'b0100, 4'b0000);
    wait_cyc(6);
    chk("t5_dout", {28'd0, dout}, 32'hE);

    // T6 reset mid-filter discards the pending fall on ch3
    filt_len = 4'd10;
    wait_cyc(1);
    drive(4'b0110, 1'b0);
    wait_cyc(5);
    rst = 1'b1;
    wait_cyc(1);
    chk("t6_rst_dout", {28'd0, dout}, 32'h0);
    chk("t6_rst_rise", {28'd0, rise}, 32'h0);
    wait_cyc(1);
    rst = 1'b0;
    exp_dout = '0;
    expect_evt(SYN + 10, 4'b0110, 4'b0000);
    wait_cyc(15);
    chk("t6_dout", {28'd0, dout}, 32'h6);
    drive(4'b1110, 1'b1);
    wait_cyc(16);
    chk("t6_dout3", {28'd0, dout}, 32'hE);

    // random changes with a full-length hold so every change is accepted
    filt_len = 4'd1;
    wait_cyc(1);
    for (int k = 0; k < 20; k++) begin
      drive(4'($urandom_range(0, 15)), 1'b1);
      wait_cyc(SYN + 3 + int'($urandom_range(0, 3)));
    end
    wait_cyc(10);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end
endmodule
